// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses SYNC/CMD/DATA/CHK frames from a byte receiver,
// writes or reads an 8x8 register bank, and answers reads through the transmitter.
module uart_cmd_ctrl #(
    parameter int BASE_FREQ     = 50_000_000,
    parameter int BAUDRATE      = 115_200,
    parameter int TIMEOUT_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [63:0] cfg_out,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt
);

    localparam int          TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (BASE_FREQ / BAUDRATE);
    localparam int          TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
    localparam logic [1:0]  ERR_NONE       = 2'b00;
    localparam logic [1:0]  ERR_CHECKSUM   = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT    = 2'b10;
    localparam logic [1:0]  ERR_ADDRESS    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_CHK,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic             rx_valid_q;
    logic             rx_valid_qq;
    logic [7:0]       cmd_q;
    logic [7:0]       data_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             byte_acc;
    logic             tmo_done;

    // A byte is accepted one cycle after the registered rx_valid rises.
    assign byte_acc = rx_valid_q & ~rx_valid_qq;
    assign tmo_done = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every state register uses <= so all of them update from the same
    // pre-edge values; a blocking assignment here would leak new values into
    // later statements of the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            // NOTE: history resets high so a level already high at reset release
            // is not mistaken for a new byte.
            rx_valid_q  <= 1'b1;
            rx_valid_qq <= 1'b1;
            cmd_q       <= '0;
            data_q      <= '0;
            tmo_cnt     <= '0;
            cfg_out     <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            frame_cnt   <= '0;
        end else begin
            rx_valid_q  <= rx_valid;
            rx_valid_qq <= rx_valid_q;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            tx_start    <= 1'b0;

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (byte_acc && rx_data == SYNC_BYTE) begin
                        state <= GET_CMD;
                    end
                end

                GET_CMD, GET_DATA, GET_CHK: begin
                    // An accepted byte always beats a timeout expiring in the same cycle.
                    if (byte_acc) begin
                        tmo_cnt <= '0;
                        case (state)
                            GET_CMD: begin
                                cmd_q <= rx_data;
                                state <= GET_DATA;
                            end
                            GET_DATA: begin
                                data_q <= rx_data;
                                state  <= GET_CHK;
                            end
                            default: begin
                                if (rx_data != (cmd_q ^ data_q)) begin
                                    frame_err <= 1'b1;
                                    err_code  <= ERR_CHECKSUM;
                                    state     <= IDLE;
                                end else if (cmd_q[6:3] != 4'b0000) begin
                                    frame_err <= 1'b1;
                                    err_code  <= ERR_ADDRESS;
                                    state     <= IDLE;
                                end else begin
                                    state <= EXEC;
                                end
                            end
                        endcase
                    end else if (tmo_done) begin
                        tmo_cnt   <= '0;
                        frame_err <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                EXEC: begin
                    frame_ok  <= 1'b1;
                    err_code  <= ERR_NONE;
                    frame_cnt <= frame_cnt + 1'b1;
                    if (cmd_q[7]) begin
                        cfg_out[{cmd_q[2:0], 3'b000} +: 8] <= data_q;
                        state <= IDLE;
                    end else begin
                        tx_data <= cfg_out[{cmd_q[2:0], 3'b000} +: 8];
                        state   <= RESP;
                    end
                end

                RESP: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus queues expected frame_ok/frame_err/tx_start
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_cmd_ctrl;

    localparam int BASE_FREQ     = 1000;
    localparam int BAUDRATE      = 100;
    localparam int TIMEOUT_BYTES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [63:0] cfg_out;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;

    uart_cmd_ctrl #(
        .BASE_FREQ     (BASE_FREQ),
        .BAUDRATE      (BAUDRATE),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .cfg_out   (cfg_out),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_OK, EV_ERR, EV_TX} ev_t;

    typedef struct {
        ev_t         kind;
        logic [1:0]  code;
        logic [63:0] cfg;
        logic [7:0]  cnt;
        logic [7:0]  tx;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_cfg    = '0;
    logic [7:0]  m_cnt    = '0;
    ev_t         mon_kind;
    exp_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input ev_t k, input logic [1:0] code, input logic [7:0] tx);
        exp_t e;
        e.kind = k;
        e.code = code;
        e.cfg  = m_cfg;
        e.cnt  = m_cnt;
        e.tx   = tx;
        exp_q.push_back(e);
    endtask

    task automatic exp_write(input int idx, input logic [7:0] data);
        m_cfg[idx*8 +: 8] = data;
        m_cnt = m_cnt + 8'd1;
        push_ev(EV_OK, 2'b00, 8'h00);
    endtask

    task automatic exp_read(input int idx, input bit with_tx);
        m_cnt = m_cnt + 8'd1;
        push_ev(EV_OK, 2'b00, 8'h00);
        if (with_tx) push_ev(EV_TX, 2'b00, m_cfg[idx*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte: rx_valid high for two cycles, then low for at least one.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(data);
        send_byte(chk);
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        m_cfg = '0;
        m_cnt = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cfg_out"},   cfg_out,          64'h0);
        check({tag, "_tx_data"},   64'(tx_data),     64'h0);
        check({tag, "_tx_start"},  64'(tx_start),    64'h0);
        check({tag, "_frame_ok"},  64'(frame_ok),    64'h0);
        check({tag, "_frame_err"}, 64'(frame_err),   64'h0);
        check({tag, "_err_code"},  64'(err_code),    64'h0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt),   64'h0);
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && (frame_ok || frame_err || tx_start)) begin
            if (frame_ok && frame_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL ok_err_exclusive: got frame_ok=1 frame_err=1 expected at most one (t=%0t)", $time);
            end
            if (tx_start && tx_busy) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_while_busy: got tx_start=1 with tx_busy=1 expected no start (t=%0t)", $time);
            end
            mon_kind = frame_ok ? EV_OK : (frame_err ? EV_ERR : EV_TX);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got %s expected no event (t=%0t)", mon_kind.name(), $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 64'(mon_kind), 64'(mon_e.kind));
                case (mon_e.kind)
                    EV_OK: begin
                        check("ok_err_code",  64'(err_code),  64'h0);
                        check("ok_cfg_out",   cfg_out,        mon_e.cfg);
                        check("ok_frame_cnt", 64'(frame_cnt), 64'(mon_e.cnt));
                    end
                    EV_ERR: begin
                        check("err_code",      64'(err_code),  64'(mon_e.code));
                        check("err_cfg_out",   cfg_out,        mon_e.cfg);
                        check("err_frame_cnt", 64'(frame_cnt), 64'(mon_e.cnt));
                    end
                    default: check("tx_data", 64'(tx_data), 64'(mon_e.tx));
                endcase
            end
        end
    end

    initial begin
        // Reset with rx_valid already high and 0xA5 on the bus: must not start a frame.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        do_reset();
        check_reset_state("reset");
        idle(5);
        rx_valid = 1'b0;
        idle(3);

        // Write 0x5C to register 3.
        exp_write(3, 8'h5C);
        send_frame(8'h83, 8'h5C, 8'hDF);

        // Read register 3 while the transmitter is busy for 20 cycles.
        tx_busy = 1'b1;
        exp_read(3, 1'b1);
        send_frame(8'h03, 8'h00, 8'h03);
        idle(20);
        tx_busy = 1'b0;
        idle(6);

        // Checksum error, address error, and both at once (checksum wins).
        push_ev(EV_ERR, 2'b01, 8'h00);
        send_frame(8'h81, 8'h11, 8'h00);
        push_ev(EV_ERR, 2'b11, 8'h00);
        send_frame(8'h88, 8'h01, 8'h89);
        push_ev(EV_ERR, 2'b01, 8'h00);
        send_frame(8'h88, 8'h01, 8'h00);

        // Inter-byte timeout (300 cycles), then a normal frame.
        push_ev(EV_ERR, 2'b10, 8'h00);
        send_byte(8'hA5);
        send_byte(8'h81);
        idle(300);
        exp_write(5, 8'hA7);
        send_frame(8'h85, 8'hA7, 8'h22);

        // Byte accepted on the very cycle the counter reaches its limit: no timeout.
        exp_write(6, 8'h3C);
        send_byte(8'hA5);
        idle(297);
        send_byte(8'h86);
        send_byte(8'h3C);
        send_byte(8'hBA);
        idle(4);

        // rx_valid held high for 50 cycles yields a single byte.
        exp_write(2, 8'h44);
        send_byte(8'hA5);
        @(negedge clk);
        rx_data  = 8'h82;
        rx_valid = 1'b1;
        idle(50);
        rx_valid = 1'b0;
        send_byte(8'h44);
        send_byte(8'hC6);
        idle(4);

        // Reset mid-frame, then a fresh frame executes from a clean bank.
        send_byte(8'hA5);
        send_byte(8'h81);
        send_byte(8'h11);
        do_reset();
        check_reset_state("midframe");
        exp_write(1, 8'h11);
        send_frame(8'h81, 8'h11, 8'h90);

        // Reset while waiting in RESP: the pending tx_start is dropped.
        tx_busy = 1'b1;
        exp_read(1, 1'b0);
        send_frame(8'h01, 8'h00, 8'h01);
        idle(4);
        do_reset();
        check_reset_state("resp");
        tx_busy = 1'b0;
        idle(10);

        // 256 writes wrap frame_cnt back to 0.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] cmd;
            logic [7:0] data;
            cmd  = 8'h80 | 8'(i % 8);
            data = 8'(i);
            exp_write(i % 8, data);
            send_frame(cmd, data, cmd ^ data);
        end
        check("wrap_frame_cnt", 64'(frame_cnt), 64'h0);
        check("wrap_cfg_out", cfg_out, 64'hFFFE_FDFC_FBFA_F9F8);

        idle(10);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
